mult32_seq: RTL

MULT32_SEQ -- requirements
Module: mult32_seq

---
 rtl/mult32_seq_pkg.sv | 39 +++
 rtl/mult32_seq_cla32.sv | 47 ++++
 rtl/mult32_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the sequential 32x32 -> 64 multiplier.
//   state_e      : controller states
//   MUL_ITER     : shift-add iterations per multiply
//   MUL_LAT_U    : start edge to done-high cycle, unsigned or positive product
//   MUL_LAT_NEG  : start edge to done-high cycle when the product is negated
//   mag32()      : two's-complement magnitude without a carry chain
package mult32_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_NEG_LO = 2'd2,
        ST_NEG_HI = 2'd3
    } state_e;

    localparam int MUL_ITER    = 32;
    localparam int MUL_LAT_U   = 33;
    localparam int MUL_LAT_NEG = 35;

    localparam logic [5:0] ITER_LAST = 6'(MUL_ITER - 1);

    // Negation by "keep bits up to and including the lowest set bit, invert
    // the rest". This is a prefix-OR, so the single shared adder stays the
    // only carry chain. 0x80000000 maps to itself, i.e. 2^31 unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic en);
        logic [31:0] r;
        logic        seen;
        r    = x;
        seen = 1'b0;
        if (en && x[31]) begin
            for (int i = 0; i < 32; i++) begin
                r[i] = x[i] ^ seen;
                seen = seen | x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult32_seq_cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit groups with group generate /
// propagate feeding the group carry chain.
//   a_i, b_i, cin_i : operands and carry-in
//   sum_o, cout_o   : 32-bit sum and carry-out
module mult32_seq_cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  gc;
    logic        grp_g;
    logic        grp_p;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c     = '0;
        gc    = '0;
        grp_g = 1'b0;
        grp_p = 1'b1;
        gc[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                grp_g = g[4*k+j] | (p[4*k+j] & grp_g);
                grp_p = grp_p & p[4*k+j];
            end
            gc[k+1] = grp_g | (grp_p & gc[k]);
        end
    end

    assign sum_o  = p ^ c;
    assign cout_o = gc[8];

endmodule

// File: rtl/mult32_seq.sv
// Sequential shift-add multiplier, MULT/MULTU semantics.
// Operands are reduced to magnitudes, multiplied over 32 iterations, and the
// 64-bit result is negated in two extra cycles when the signs differ.
//   clk, rst_n      : clock, async active-low reset
//   start           : request (accepted only in IDLE)
//   is_signed, a, b : operation and operands, sampled with start
//   busy            : high outside IDLE
//   done            : one-cycle pulse when hi/lo update
//   hi, lo          : upper / lower word of the last product
//
// state     | meaning
// ST_IDLE   | waiting for start; hi/lo hold last result
// ST_CALC   | 32 shift-add iterations on {acc, mplier}
// ST_NEG_LO | low word := ~mplier + 1, carry stored
// ST_NEG_HI | high word := ~acc + carry, result published
module mult32_seq
    import mult32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        carry_q, carry_d;
    logic        done_q, done_d;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_co;

    // Operand mux for the one shared adder; depends on registers only.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_CALC: begin
                add_a = acc_q;
                add_b = mplier_q[0] ? mcand_q : 32'd0;
            end
            ST_NEG_LO: begin
                add_a   = ~mplier_q;
                add_cin = 1'b1;
            end
            ST_NEG_HI: begin
                add_a   = ~acc_q;
                add_cin = carry_q;
            end
            default: ;
        endcase
    end

    mult32_seq_cla32 u_cla (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_co)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = mag32(a, is_signed);
                    mplier_d = mag32(b, is_signed);
                    neg_d    = is_signed & (a[31] ^ b[31]);
                    acc_d    = '0;
                    carry_d  = 1'b0;
                    cnt_d    = ITER_LAST;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                // {acc, mplier} <= {carry, sum, mplier} >> 1
                acc_d    = {add_co, add_sum[31:1]};
                mplier_d = {add_sum[0], mplier_q[31:1]};
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else if (neg_q) begin
                    state_d = ST_NEG_LO;
                end else begin
                    hi_d    = {add_co, add_sum[31:1]};
                    lo_d    = {add_sum[0], mplier_q[31:1]};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_NEG_LO: begin
                mplier_d = add_sum;
                carry_d  = add_co;
                state_d  = ST_NEG_HI;
            end
            ST_NEG_HI: begin
                acc_d   = add_sum;
                hi_d    = add_sum;
                lo_d    = mplier_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
